// File: rtl/hex_arb_pkg.sv
// -----------------------------------------------------------------------------
// hex_arb_pkg
// Shared types and constants for the HEX display arbiter.
//   state_t       : arbiter states IDLE / OWN / GAP
//   BLANK_NIBBLE  : nibble value that decodes to a dark digit
//   SEG_BLANK     : active-low segment pattern for a dark digit
//   MAX_REQ       : widest request vector first_set() accepts
//   first_set()   : index of the lowest set request bit (highest priority)
// -----------------------------------------------------------------------------
package hex_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_NIBBLE = 4'hF;
    localparam logic [6:0] SEG_BLANK    = 7'h7F;
    localparam int         MAX_REQ      = 32;

    // Scan from the top down so the lowest set bit is the last one written.
    function automatic logic [4:0] first_set(input logic [MAX_REQ-1:0] req);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = i[4:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hex_display_arbiter_seg7.sv
// -----------------------------------------------------------------------------
// seg7
// BCD to active-low seven-segment decoder (bit order g f e d c b a).
//   bcd_i  : 4-bit digit value
//   leds_o : segment drive, 0 = lit; codes above 9 come out dark
// -----------------------------------------------------------------------------
module seg7 (
    input  logic [3:0] bcd_i,
    output logic [6:0] leds_o
);

    // Digit lookup.
    always_comb begin
        case (bcd_i)
            4'd0:    leds_o = 7'b1000000;
            4'd1:    leds_o = 7'b1111001;
            4'd2:    leds_o = 7'b0100100;
            4'd3:    leds_o = 7'b0110000;
            4'd4:    leds_o = 7'b0011001;
            4'd5:    leds_o = 7'b0010010;
            4'd6:    leds_o = 7'b0000010;
            4'd7:    leds_o = 7'b1111000;
            4'd8:    leds_o = 7'b0000000;
            4'd9:    leds_o = 7'b0010000;
            default: leds_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/hex_display_arbiter.sv
// -----------------------------------------------------------------------------
// hex_display_arbiter
// Shares the HEX displays between N_REQ requesters. Fixed priority (req[0]
// highest), minimum ownership of HOLD_CYCLES, one blank gap cycle between
// owners. Digits above 9 are forced dark after the seg7 decoders.
// Optional feature macro: HEX_ARB_BLINK_EN (adds the blink port and a blink
// counter that runs only while a requester owns the display).
// Ports:
//   clk     : system clock
//   reset   : asynchronous active-high reset
//   req     : level request per requester
//   data_i  : requester r digit d at [(r*N_DIGITS+d)*4 +: 4]
//   blink   : per-requester blink request (HEX_ARB_BLINK_EN only)
//   grant   : registered one-hot owner, or zero
//   busy    : registered, high while a requester owns the display
//   hex_o   : registered active-low digits, digit d at [d*7 +: 7]
// -----------------------------------------------------------------------------
module hex_display_arbiter
    import hex_arb_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int N_DIGITS     = 6,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*N_DIGITS*4-1:0] data_i,
`ifdef HEX_ARB_BLINK_EN
    input  logic [N_REQ-1:0]            blink,
`endif
    output logic [N_REQ-1:0]            grant,
    output logic                        busy,
    output logic [N_DIGITS*7-1:0]       hex_o
);

    localparam int DW = N_DIGITS * 4;
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [OW-1:0]           owner_q, owner_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic [DW-1:0]           snap_q, snap_d;
    logic [N_REQ-1:0]        grant_q, grant_d;
    logic                    busy_q, busy_d;
    logic [N_DIGITS*7-1:0]   hex_q, hex_d;

    logic [MAX_REQ-1:0]      req_ext_s;
    logic [OW-1:0]           first_idx_s;
    logic [DW-1:0]           first_data_s;
    logic [DW-1:0]           owner_data_s;
    logic                    owner_req_s;
    logic                    higher_req_s;
    logic [N_DIGITS*7-1:0]   seg_s;
    logic [N_DIGITS*7-1:0]   digits_s;
    logic                    blank_phase_s;

    // Widen the request vector for the package priority encoder.
    always_comb begin
        req_ext_s            = {MAX_REQ{1'b0}};
        req_ext_s[N_REQ-1:0] = req;
    end

    assign first_idx_s = OW'(first_set(req_ext_s));

    // Per-requester selections: winner data, owner data/request, higher-priority request.
    always_comb begin
        first_data_s = {DW{1'b0}};
        owner_data_s = {DW{1'b0}};
        owner_req_s  = 1'b0;
        higher_req_s = 1'b0;
        for (int r = 0; r < N_REQ; r++) begin
            first_data_s = (first_idx_s == OW'(r)) ? data_i[r*DW +: DW] : first_data_s;
            owner_data_s = (owner_q == OW'(r)) ? data_i[r*DW +: DW] : owner_data_s;
            owner_req_s  = (owner_q == OW'(r)) ? req[r] : owner_req_s;
            higher_req_s = higher_req_s | (req[r] & (OW'(r) < owner_q));
        end
    end

    // Arbitration, hold timing and snapshot capture.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        snap_d  = snap_q;
        case (state_q)
            IDLE, GAP: begin
                if (|req) begin
                    state_d = OWN;
                    owner_d = first_idx_s;
                    hold_d  = HOLD_LOAD;
                    snap_d  = first_data_s;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                // A dropped request freezes the last captured digits.
                snap_d = owner_req_s ? owner_data_s : snap_q;
                if (hold_q != {HW{1'b0}}) begin
                    hold_d  = hold_q - HW'(1);
                    state_d = OWN;
                end else if (!owner_req_s || higher_req_s) begin
                    state_d = GAP;
                end else begin
                    state_d = OWN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One decoder per digit; the blank mux sits after each decoder.
    for (genvar d = 0; d < N_DIGITS; d++) begin : g_digit
        seg7 u_seg7 (
            .bcd_i  (snap_q[d*4 +: 4]),
            .leds_o (seg_s[d*7 +: 7])
        );
        assign digits_s[d*7 +: 7] = (snap_q[d*4 +: 4] > 4'd9) ? SEG_BLANK : seg_s[d*7 +: 7];
    end

`ifdef HEX_ARB_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic          owner_blink_s;

    // Blink half-period counter; restarts visible on every new grant.
    always_comb begin
        owner_blink_s = 1'b0;
        for (int r = 0; r < N_REQ; r++) begin
            owner_blink_s = (owner_q == OW'(r)) ? blink[r] : owner_blink_s;
        end
        if ((state_q == OWN) && (state_d == OWN)) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = {BW{1'b0}};
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + BW'(1);
                blink_phase_d = blink_phase_q;
            end
        end else begin
            blink_cnt_d   = {BW{1'b0}};
            blink_phase_d = 1'b0;
        end
        blank_phase_s = owner_blink_s & blink_phase_q;
    end

    // Blink counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q   <= {BW{1'b0}};
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end
`else
    localparam int cfg_unused_blink = BLINK_CYCLES;
    assign blank_phase_s = 1'b0;
`endif

    // Registered outputs: grant/busy follow the next state, digits lag the snapshot by one stage.
    always_comb begin
        grant_d = {N_REQ{1'b0}};
        for (int r = 0; r < N_REQ; r++) begin
            grant_d[r] = (state_d == OWN) && (owner_d == OW'(r));
        end
        busy_d = (state_d == OWN);
        hex_d  = ((state_q == OWN) && !blank_phase_s) ? digits_s : {N_DIGITS{SEG_BLANK}};
    end

    // Arbiter state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= {OW{1'b0}};
            hold_q  <= {HW{1'b0}};
            snap_q  <= {N_DIGITS{BLANK_NIBBLE}};
            grant_q <= {N_REQ{1'b0}};
            busy_q  <= 1'b0;
            hex_q   <= {N_DIGITS{SEG_BLANK}};
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            snap_q  <= snap_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            hex_q   <= hex_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign hex_o = hex_q;

endmodule
